// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
// Provides bus widths, the halt encoding, the PC step and the queue-entry payload.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned INSTR_BYTES = 2;

  localparam logic [DATA_W-1:0] HALT_WORD = 16'hEFFF;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of fetch entries.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   push, wdata   - enqueue request and payload (accepted when not full or popping)
//   pop           - dequeue request (ignored when empty)
//   flush         - discard all entries; wins over push and pop
//   head          - oldest entry, all zeros when empty
//   count, full   - occupancy and full flag
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue can still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : entries[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) entries[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the fetch address, captures the returned
// word into a prefetch queue and hands instructions to decode.
// Ports:
//   Clock, Reset          - clock and synchronous active-high reset
//   IAddress, IReadData   - instruction memory address and combinational read word
//   Redirect, RedirectPC  - branch taken: flush queue and refetch from target
//   InstrValid, Instr,
//   InstrPC, InstrReady   - decode handshake for the queue head
//   Halted                - halt word fetched; no further fetches until redirect/reset
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] IAddress,
  input  logic [DATA_W-1:0] IReadData,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  input  logic              InstrReady,
  output logic              Halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              halt_latch;
  logic              pop;
  logic              push;
  logic              q_full;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_wdata;

  assign IAddress   = fetch_pc;
  assign InstrValid = (q_count != '0);
  assign Instr      = q_head.instr;
  assign InstrPC    = q_head.pc;
  assign Halted     = halt_latch;

  assign pop  = InstrValid & InstrReady;
  assign push = ~Redirect & ~halt_latch & (~q_full | pop);

  assign q_wdata = '{instr: IReadData, pc: fetch_pc};

  // PC and halt control; a redirect discards this cycle's fetch, costing one bubble.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc   <= RESET_PC;
      halt_latch <= 1'b0;
    end else if (Redirect) begin
      fetch_pc   <= {RedirectPC[ADDR_W-1:1], 1'b0};
      halt_latch <= 1'b0;
    end else if (push) begin
      fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
      if (IReadData == HALT_WORD) halt_latch <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clock(Clock),
    .reset(Reset),
    .push (push),
    .pop  (pop),
    .flush(Redirect),
    .wdata(q_wdata),
    .head (q_head),
    .count(q_count),
    .full (q_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: byte memory model, queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] HALT   = 16'hEFFF;

  logic        Clock;
  logic        Reset;
  logic [15:0] IAddress;
  logic [15:0] IReadData;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        InstrValid;
  logic [15:0] Instr;
  logic [15:0] InstrPC;
  logic        InstrReady;
  logic        Halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [65536];

  assign IReadData = {mem[IAddress + 16'd1], mem[IAddress]};

  instr_fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .IAddress(IAddress),
    .IReadData(IReadData),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC),
    .InstrValid(InstrValid),
    .Instr(Instr),
    .InstrPC(InstrPC),
    .InstrReady(InstrReady),
    .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] w);
    logic [15:0] a1;
    a1 = a + 16'd1;
    mem[a]  = w[7:0];
    mem[a1] = w[15:8];
  endtask

  // Reference model: an abstract queue of (instr, pc) plus next fetch address and halt flag.
  logic [15:0] mq_instr [$];
  logic [15:0] mq_pc    [$];
  logic [15:0] m_pc     = 16'h0;
  logic        m_halt   = 1'b0;
  logic        m_live   = 1'b0;

  always @(posedge Clock) begin
    logic [15:0] word;
    logic [15:0] pc1;
    logic        do_pop;
    logic        do_push;
    if (Reset) begin
      mq_instr.delete();
      mq_pc.delete();
      m_pc   = RST_PC;
      m_halt = 1'b0;
      m_live = 1'b1;
    end else if (Redirect) begin
      mq_instr.delete();
      mq_pc.delete();
      m_pc   = RedirectPC & 16'hFFFE;
      m_halt = 1'b0;
    end else begin
      pc1     = m_pc + 16'd1;
      word    = {mem[pc1], mem[m_pc]};
      do_pop  = (mq_pc.size() != 0) && InstrReady;
      do_push = !m_halt && ((mq_pc.size() < DEPTH) || do_pop);
      if (do_pop) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_instr.push_back(word);
        mq_pc.push_back(m_pc);
        if (word == HALT) m_halt = 1'b1;
        m_pc = m_pc + 16'd2;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (m_live) begin
      chk("m_iaddr", IAddress, m_pc);
      chk("m_valid", 16'(InstrValid), 16'(mq_pc.size() != 0));
      chk("m_instr", Instr, (mq_pc.size() != 0) ? mq_instr[0] : 16'h0);
      chk("m_pc", InstrPC, (mq_pc.size() != 0) ? mq_pc[0] : 16'h0);
      chk("m_halted", 16'(Halted), 16'(m_halt));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic head(input string name, input logic v, input logic [15:0] i,
                      input logic [15:0] p, input logic [15:0] a);
    chk({name, "_valid"}, 16'(InstrValid), 16'(v));
    chk({name, "_instr"}, Instr, i);
    chk({name, "_pc"}, InstrPC, p);
    chk({name, "_iaddr"}, IAddress, a);
  endtask

  initial begin
    Reset      = 1'b1;
    Redirect   = 1'b0;
    RedirectPC = 16'h0;
    InstrReady = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    set_word(16'd0, 16'h0120);
    set_word(16'd2, 16'h0121);
    set_word(16'd4, 16'h0341);
    for (int a = 6; a <= 48; a += 2) set_word(16'(a), 16'(16'h1000 + a));
    set_word(16'd50, HALT);
    set_word(16'hFFFE, 16'h5AFE);

    // Reset state, then back-to-back delivery.
    tick();
    head("rst", 1'b0, 16'h0, 16'h0, 16'h0);
    chk("rst_halted", 16'(Halted), 16'h0);
    Reset = 1'b0; InstrReady = 1'b1;
    tick(); head("s1a", 1'b1, 16'h0120, 16'd0, 16'd2);
    tick(); head("s1b", 1'b1, 16'h0121, 16'd2, 16'd4);
    tick(); head("s1c", 1'b1, 16'h0341, 16'd4, 16'd6);

    // Backpressure from reset: queue saturates, then drains in order.
    Reset = 1'b1; InstrReady = 1'b0;
    tick(); head("s2rst", 1'b0, 16'h0, 16'h0, 16'h0);
    Reset = 1'b0;
    repeat (5) tick();
    head("s2full", 1'b1, 16'h0120, 16'd0, 16'd4);
    InstrReady = 1'b1;
    tick(); head("s2d1", 1'b1, 16'h0121, 16'd2, 16'd6);
    tick(); head("s2d2", 1'b1, 16'h0341, 16'd4, 16'd8);
    tick(); tick();
    head("s2d4", 1'b1, 16'h1008, 16'd8, 16'd12);

    // Redirect to an odd target while the head is offered: flush and one bubble.
    Redirect = 1'b1; RedirectPC = 16'h0023;
    tick(); head("s3flush", 1'b0, 16'h0, 16'h0, 16'h0022);
    Redirect = 1'b0;
    tick(); head("s3tgt", 1'b1, 16'h1022, 16'h0022, 16'h0024);

    // Halt word: still delivered, fetching freezes, redirect resumes.
    Redirect = 1'b1; RedirectPC = 16'd48; InstrReady = 1'b0;
    tick(); head("s4rd", 1'b0, 16'h0, 16'h0, 16'd48);
    Redirect = 1'b0;
    tick(); tick();
    head("s4q", 1'b1, 16'h1030, 16'd48, 16'd52);
    chk("s4_halted", 16'(Halted), 16'h1);
    tick(); chk("s4_frozen", IAddress, 16'd52);
    InstrReady = 1'b1;
    tick(); head("s4h", 1'b1, HALT, 16'd50, 16'd52);
    tick(); head("s4e", 1'b0, 16'h0, 16'h0, 16'd52);
    tick(); head("s4e2", 1'b0, 16'h0, 16'h0, 16'd52);
    chk("s4_still_halted", 16'(Halted), 16'h1);
    Redirect = 1'b1; RedirectPC = 16'h0;
    tick(); head("s4clr", 1'b0, 16'h0, 16'h0, 16'd0);
    chk("s4_unhalted", 16'(Halted), 16'h0);
    Redirect = 1'b0;
    tick(); head("s4res", 1'b1, 16'h0120, 16'd0, 16'd2);

    // Address wrap at the top of memory.
    Redirect = 1'b1; RedirectPC = 16'hFFFE;
    tick(); head("s5rd", 1'b0, 16'h0, 16'h0, 16'hFFFE);
    Redirect = 1'b0;
    tick(); head("s5top", 1'b1, 16'h5AFE, 16'hFFFE, 16'h0000);
    tick(); head("s5wrap", 1'b1, 16'h0120, 16'h0000, 16'h0002);

    // Reset beats a simultaneous redirect with a full queue.
    InstrReady = 1'b0;
    tick(); tick();
    Reset = 1'b1; Redirect = 1'b1; RedirectPC = 16'h0040;
    tick(); head("s6", 1'b0, 16'h0, 16'h0, RST_PC);
    chk("s6_halted", 16'(Halted), 16'h0);
    Reset = 1'b0; Redirect = 1'b0; InstrReady = 1'b1;
    tick(); head("s6run", 1'b1, 16'h0120, 16'd0, 16'd2);
    repeat (4) tick();

    @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
